key_scan_sched: RTL and testbench

Round-robin debounce scheduler that shares one glitch-filter timer among `KEY_CNT` active-low key inputs. It synchronizes all keys and scans them in turn. It locks onto the first key found pressed, qualifies the press with the shared timer, and reports it over a valid/ready event interface. It then waits for a debounced release before resuming the scan. It sits between raw board keys and the control logic that consumes key events, replacing one debouncer instance per key.

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/key_sync.sv | 39 +++
 rtl/key_scan_sched.sv | 135 +++++++++++++
 tb/tb_key_scan_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and helpers for the key debounce blocks.
//   sched_state_t : scheduler FSM states (IDLE, SETTLE, REPORT, RELEASE)
//   glitch_cycles : number of clock cycles covering a glitch-filter window,
//                   rounded up so the window is never shorter than requested
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        REPORT  = 2'd2,
        RELEASE = 2'd3
    } sched_state_t;

    // ceil(time_ns * freq_mhz / 1000) in integer arithmetic
    function automatic int glitch_cycles(input int freq_mhz, input int time_ns);
        return (time_ns * freq_mhz + 999) / 1000;
    endfunction

endpackage

// File: rtl/key_sync.sv
// -----------------------------------------------------------------------------
// key_sync
// Two-flop synchronizer for a vector of independent asynchronous inputs.
// Resets to all ones so that active-low keys read as released out of reset.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   d_i    : raw asynchronous inputs
//   q_o    : synchronized inputs
// -----------------------------------------------------------------------------
module key_sync #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_scan_sched.sv
// -----------------------------------------------------------------------------
// key_scan_sched
// Round-robin debounce scheduler: one shared glitch timer serves KEY_CNT
// active-low keys. Keys are scanned one per cycle; the first pressed key is
// locked, qualified for CLK_CYCLES stable cycles, reported once over a
// valid/ready interface, and then must be released for CLK_CYCLES stable
// cycles before the scan resumes at the key after the locked one.
//
// Handshake: event_valid_o is held high with event_key_o stable until the
// cycle where event_valid_o && event_ready_i; that cycle transfers the event
// and valid drops on the next cycle.
//
//   clk_i         : clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   keys_i        : raw asynchronous keys, 0 = pressed
//   event_ready_i : consumer accepts the event
//   event_valid_o : debounced press event available
//   event_key_o   : index of the locked key (driven in every state)
//   busy_o        : scheduler is not in IDLE
// -----------------------------------------------------------------------------
module key_scan_sched
    import debounce_pkg::*;
#(
    parameter  int CLK_FREQ_MHZ   = 200,
    parameter  int GLITCH_TIME_NS = 500,
    parameter  int KEY_CNT        = 4,
    localparam int KEY_W          = (KEY_CNT <= 2) ? 1 : $clog2(KEY_CNT)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [KEY_CNT-1:0] keys_i,
    input  logic               event_ready_i,
    output logic               event_valid_o,
    output logic [KEY_W-1:0]   event_key_o,
    output logic               busy_o
);

    localparam int CLK_CYCLES = glitch_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);
    localparam int CNT_W      = $clog2(CLK_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_CYCLES - 1);
    localparam logic [KEY_W-1:0] KEY_LAST = KEY_W'(KEY_CNT - 1);

    if (CLK_CYCLES < 2) begin : g_bad_glitch_time
        $error("key_scan_sched: glitch window must span at least 2 clock cycles");
    end
    if (KEY_CNT < 2 || KEY_CNT > 64) begin : g_bad_key_cnt
        $error("key_scan_sched: KEY_CNT must be within 2..64");
    end

    // KEY_CNT need not be a power of two, so wrap explicitly.
    function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] k);
        return (k == KEY_LAST) ? '0 : k + KEY_W'(1);
    endfunction

    logic [KEY_CNT-1:0] keys_s;

    key_sync #(.W(KEY_CNT)) u_key_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (keys_i),
        .q_o    (keys_s)
    );

    sched_state_t     state_d, state_q;
    logic [KEY_W-1:0] ptr_d,   ptr_q;
    logic [KEY_W-1:0] lock_d,  lock_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!keys_s[ptr_q]) begin
                    lock_d  = ptr_q;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    ptr_d = next_key(ptr_q);
                end
            end
            SETTLE: begin
                // A bounce back to released aborts; scanning resumes past it.
                if (keys_s[lock_q]) begin
                    state_d = IDLE;
                    ptr_d   = next_key(lock_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPORT: begin
                // Key level is ignored here: a raised event is never withdrawn.
                if (event_ready_i) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (!keys_s[lock_q]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    ptr_d   = next_key(lock_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign event_valid_o = (state_q == REPORT);
    assign event_key_o   = lock_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_key_scan_sched.sv
module tb_key_scan_sched;
    import debounce_pkg::*;

    localparam int KEY_CNT = 4;
    localparam int KEY_W   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [KEY_CNT-1:0] keys;
    logic               ready;
    logic               valid;
    logic [KEY_W-1:0]   key_idx;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [KEY_W-1:0] exp_q[$];

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    key_scan_sched #(
        .CLK_FREQ_MHZ   (100),
        .GLITCH_TIME_NS (100),
        .KEY_CNT        (KEY_CNT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .keys_i        (keys),
        .event_ready_i (ready),
        .event_valid_o (valid),
        .event_key_o   (key_idx),
        .busy_o        (busy)
    );

    // ------------------------------------------------------------ checking
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every transferred event must match the next expected key.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'(exp_q.size()), 64'd1);
            end else begin
                check("event_key_sb", 64'(key_idx), 64'(exp_q.pop_front()));
            end
        end
    end

    // ------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Wait until the scan pointer holds p (it advances every idle cycle).
    task automatic align_ptr(input logic [KEY_W-1:0] p);
        int n;
        n = 0;
        while (dut.ptr_q !== p && n < 8) begin
            tick();
            n++;
        end
        if (dut.ptr_q !== p) check("align_ptr_timeout", 64'(dut.ptr_q), 64'(p));
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (valid !== 1'b1) check(tag, 64'(valid), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) check(tag, 64'(busy), 64'd0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic saw_valid;
        logic [KEY_W-1:0] held_key;

        rst_n = 1'b0;
        keys  = '1;
        ready = 1'b0;
        ticks(2);

        // reset state
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_key", 64'(key_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'(IDLE));
        rst_n = 1'b1;

        // clean press on key 2, scan reaching key 2 exactly when keys_s drops
        align_ptr(2'd0);
        exp_q.push_back(2'd2);
        ready   = 1'b1;
        keys[2] = 1'b0;
        ticks(12);
        check("press_valid_early", 64'(valid), 64'd0);
        check("press_busy", 64'(busy), 64'd1);
        tick();
        check("press_valid", 64'(valid), 64'd1);
        check("press_key", 64'(key_idx), 64'd2);
        tick();
        check("press_valid_drop", 64'(valid), 64'd0);
        check("press_state_rel", 64'(dut.state_q), 64'(RELEASE));
        keys = '1;
        ticks(11);
        check("release_busy_hold", 64'(busy), 64'd1);
        tick();
        check("release_busy_done", 64'(busy), 64'd0);
        check("release_ptr", 64'(dut.ptr_q), 64'd3);

        // key 1 glitch: low for 7 sampled cycles, then high -> abort
        align_ptr(2'd3);
        saw_valid = 1'b0;
        keys[1]   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            saw_valid |= valid;
        end
        keys[1] = 1'b1;
        tick();
        saw_valid |= valid;
        tick();
        saw_valid |= valid;
        check("glitch_settle_busy", 64'(busy), 64'd1);
        check("glitch_settle_lock", 64'(dut.lock_q), 64'd1);
        tick();
        saw_valid |= valid;
        check("glitch_abort_idle", 64'(dut.state_q), 64'(IDLE));
        check("glitch_abort_ptr", 64'(dut.ptr_q), 64'd2);
        check("glitch_no_event", 64'(saw_valid), 64'd0);

        // ready held low: event held stable while the key is released
        ready   = 1'b0;
        keys[0] = 1'b0;
        wait_valid("backpressure_valid_timeout", 40);
        check("backpressure_key", 64'(key_idx), 64'd0);
        held_key = key_idx;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) keys = '1;
            tick();
            check("backpressure_valid_hold", 64'(valid), 64'd1);
            check("backpressure_key_hold", 64'(key_idx), 64'(held_key));
        end
        exp_q.push_back(2'd0);
        ready = 1'b1;
        tick();
        check("backpressure_valid_drop", 64'(valid), 64'd0);
        check("backpressure_busy", 64'(busy), 64'd1);
        ticks(9);
        check("backpressure_rel_hold", 64'(busy), 64'd1);
        tick();
        check("backpressure_rel_done", 64'(busy), 64'd0);
        check("backpressure_ptr", 64'(dut.ptr_q), 64'd1);

        // keys 0 and 3 together: 0 first, then 3, no repeat of 0
        align_ptr(2'd2);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        keys[0] = 1'b0;
        keys[3] = 1'b0;
        wait_valid("dual_first_timeout", 30);
        check("dual_first_key", 64'(key_idx), 64'd0);
        tick();
        check("dual_first_drop", 64'(valid), 64'd0);
        keys[0] = 1'b1;
        wait_valid("dual_second_timeout", 60);
        check("dual_second_key", 64'(key_idx), 64'd3);
        tick();
        keys[3] = 1'b1;
        wait_idle("dual_idle_timeout", 30);
        check("dual_events_drained", 64'(exp_q.size()), 64'd0);

        // release bounce: high 5, low 1, high 10
        align_ptr(2'd0);
        exp_q.push_back(2'd2);
        keys[2] = 1'b0;
        wait_valid("bounce_valid_timeout", 30);
        check("bounce_key", 64'(key_idx), 64'd2);
        tick();
        keys[2] = 1'b1;
        ticks(5);
        keys[2] = 1'b0;
        tick();
        keys[2] = 1'b1;
        ticks(11);
        check("bounce_still_release", 64'(dut.state_q), 64'(RELEASE));
        tick();
        check("bounce_idle", 64'(dut.state_q), 64'(IDLE));

        // reset pulse during REPORT drops the pending event asynchronously
        ready   = 1'b0;
        keys[1] = 1'b0;
        wait_valid("reset_valid_timeout", 30);
        check("reset_pre_valid", 64'(valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_valid", 64'(valid), 64'd0);
        check("reset_async_busy", 64'(busy), 64'd0);
        keys = '1;
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_after_state", 64'(dut.state_q), 64'(IDLE));
        check("reset_after_valid", 64'(valid), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
